// File: rtl/pmu_ahb_pkg.sv
// Shared constants for the PMU AHB slave: register map indices, CTRL bits,
// AHB encodings and the bus-side FSM state type.
package pmu_ahb_pkg;

  localparam int CTRL_IDX        = 0;
  localparam int CNT_BASE        = 1;
  localparam int OVF_MASK_IDX    = 25;
  localparam int OVF_STATUS_IDX  = 26;
  localparam int QUOTA_MASK_IDX  = 27;
  localparam int QUOTA_LIMIT_IDX = 28;
  localparam int SCRATCH_BASE    = 29;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_CLR  = 1;
  localparam int CTRL_MCCU = 2;

  typedef enum logic [1:0] {HRESP_OKAY = 2'b00, HRESP_ERROR = 2'b01} hresp_e;
  typedef enum logic [1:0] {
    HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} bus_st_e;

  // MCCU budgets occupy the top MCCU_N_CORES words of the register file.
  function automatic int mccu_base(input int n_regs, input int n_cores);
    return n_regs - n_cores;
  endfunction

endpackage

// File: rtl/pmu_ahb_slave_if.sv
// AHB-Lite signal bundle between the bus fabric and the PMU slave.
interface pmu_ahb_slave_if #(parameter int DW = 32);
  logic          hsel_i;
  logic          hreadyi_i;
  logic [31:0]   haddr_i;
  logic          hwrite_i;
  logic [1:0]    htrans_i;
  logic [2:0]    hsize_i;
  logic [2:0]    hburst_i;
  logic [DW-1:0] hwdata_i;
  logic [3:0]    hprot_i;
  logic          hmastlock_i;
  logic          hreadyo_o;
  logic [1:0]    hresp_o;
  logic [DW-1:0] hrdata_o;

  modport master (
    output hsel_i, hreadyi_i, haddr_i, hwrite_i, htrans_i, hsize_i, hburst_i,
           hwdata_i, hprot_i, hmastlock_i,
    input  hreadyo_o, hresp_o, hrdata_o
  );

  modport slave (
    input  hsel_i, hreadyi_i, haddr_i, hwrite_i, htrans_i, hsize_i, hburst_i,
           hwdata_i, hprot_i, hmastlock_i,
    output hreadyo_o, hresp_o, hrdata_o
  );
endinterface

// File: rtl/pmu_ahb_if.sv
// AHB address/data phase tracking, register decode and response FSM.
// PMU_AHB_ERR_RESP_EN: invalid accesses get a two-cycle ERROR instead of OKAY.
module pmu_ahb_if
  import pmu_ahb_pkg::*;
#(
  parameter logic [31:0] haddr  = 32'h80100000,
  parameter logic [31:0] hmask  = 32'hfff,
  parameter int          N_REGS = 47,
  parameter int          IDX_W  = $clog2(N_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hsel_i,
  input  logic             hreadyi_i,
  input  logic             htrans_nseq,
  input  logic             hwrite_i,
  input  logic [31:0]      haddr_i,
  output logic             hreadyo,
  output logic [1:0]       hresp,
  output logic             wr_en,
  output logic             rd_en,
  output logic [IDX_W-1:0] idx
);

`ifdef PMU_AHB_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  bus_st_e           state_q, state_d;
  logic              active, hit;
  logic [31:0]       off;
  logic              write_q, hit_q;
  logic [IDX_W-1:0]  idx_q;

  assign active = hsel_i & hreadyi_i & htrans_nseq;
  assign off    = (haddr_i & hmask) >> 2;
  assign hit    = ((haddr_i & ~hmask) == (haddr & ~hmask)) && (off < 32'(N_REGS));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: if (active) state_d = (hit || !ERR_EN) ? ST_DATA : ST_ERR1;
    endcase
  end

  always_comb begin
    hreadyo = 1'b1;
    hresp   = HRESP_OKAY;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      ST_DATA: begin
        wr_en = hit_q & write_q;
        rd_en = hit_q & ~write_q;
      end
      ST_ERR1: begin
        hreadyo = 1'b0;
        hresp   = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  // Address-phase capture; ERR1 stalls the bus so nothing new is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_q <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
    end else if (active && state_q != ST_ERR1) begin
      write_q <= hwrite_i;
      hit_q   <= hit;
      idx_q   <= off[IDX_W-1:0];
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/pmu_ahb_slave.sv
// PMU register file on AHB-Lite: event counters, overflow/quota interrupts,
// MCCU budgets and optional parity. Error response via PMU_AHB_ERR_RESP_EN.
module pmu_ahb_slave
  import pmu_ahb_pkg::*;
#(
  parameter logic [31:0] haddr        = 32'h80100000,
  parameter logic [31:0] hmask        = 32'hfff,
  parameter int          REG_WIDTH    = 32,
  parameter int          N_REGS       = 47,
  parameter int          N_COUNTERS   = 24,
  parameter int          MCCU_N_CORES = 4,
  parameter int          N_SOC_EV     = 32,
  parameter int          FT           = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  pmu_ahb_slave_if.slave          ahb,
  input  logic [N_SOC_EV-1:0]     events_i,
  output logic                    intr_overflow_o,
  output logic                    intr_quota_o,
  output logic [MCCU_N_CORES-1:0] intr_MCCU_o,
  output logic                    intr_RDC_o,
  output logic                    intr_FT1_o,
  output logic                    intr_FT2_o
);

  localparam int IDX_W = $clog2(N_REGS);
  localparam int MB    = mccu_base(N_REGS, MCCU_N_CORES);
  localparam int SUM_W = REG_WIDTH + $clog2(N_COUNTERS);

  logic [N_REGS-1:0][REG_WIDTH-1:0] regs_q, regs_d;
  logic [N_COUNTERS-1:0]            ovf_set;
  logic [REG_WIDTH-1:0]             ctrl;
  logic                             wr_en, rd_en;
  logic [IDX_W-1:0]                 idx;
  logic [SUM_W-1:0]                 q_sum;

  pmu_ahb_if #(.haddr(haddr), .hmask(hmask), .N_REGS(N_REGS), .IDX_W(IDX_W)) u_bus (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .hsel_i      (ahb.hsel_i),
    .hreadyi_i   (ahb.hreadyi_i),
    .htrans_nseq (ahb.htrans_i[1]),
    .hwrite_i    (ahb.hwrite_i),
    .haddr_i     (ahb.haddr_i),
    .hreadyo     (ahb.hreadyo_o),
    .hresp       (ahb.hresp_o),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .idx         (idx)
  );

  assign ctrl         = regs_q[CTRL_IDX];
  assign ahb.hrdata_o = rd_en ? regs_q[idx] : '0;

  // Hardware updates first, bus write last so it overrides them.
  always_comb begin
    regs_d  = regs_q;
    ovf_set = '0;
    regs_d[CTRL_IDX][CTRL_CLR] = 1'b0;
    for (int i = 0; i < N_COUNTERS; i++) begin
      if (ctrl[CTRL_CLR]) begin
        regs_d[CNT_BASE+i] = '0;
      end else if (ctrl[CTRL_EN] && events_i[i]) begin
        regs_d[CNT_BASE+i] = regs_q[CNT_BASE+i] + 1'b1;
        ovf_set[i]         = &regs_q[CNT_BASE+i];
      end
    end
    regs_d[OVF_STATUS_IDX] = ctrl[CTRL_CLR] ? '0
                           : regs_q[OVF_STATUS_IDX] | REG_WIDTH'(ovf_set);
    for (int c = 0; c < MCCU_N_CORES; c++)
      if (ctrl[CTRL_MCCU] && events_i[N_COUNTERS+c] && |regs_q[MB+c])
        regs_d[MB+c] = regs_q[MB+c] - 1'b1;
    if (wr_en) begin
      if (idx == IDX_W'(OVF_STATUS_IDX))
        regs_d[OVF_STATUS_IDX] = regs_q[OVF_STATUS_IDX] & ~ahb.hwdata_i;
      else
        regs_d[idx] = ahb.hwdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  always_comb begin
    q_sum = '0;
    for (int i = 0; i < N_COUNTERS; i++)
      if (regs_q[QUOTA_MASK_IDX][i]) q_sum = q_sum + SUM_W'(regs_q[CNT_BASE+i]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      intr_overflow_o <= 1'b0;
      intr_quota_o    <= 1'b0;
    end else begin
      intr_overflow_o <= |(regs_q[OVF_STATUS_IDX] & regs_q[OVF_MASK_IDX]);
      intr_quota_o    <= (|regs_q[QUOTA_MASK_IDX]) && (q_sum >= SUM_W'(regs_q[QUOTA_LIMIT_IDX]));
    end
  end

  for (genvar c = 0; c < MCCU_N_CORES; c++) begin : g_mccu
    assign intr_MCCU_o[c] = ctrl[CTRL_MCCU] & ~|regs_q[MB+c];
  end

  assign intr_RDC_o = 1'b0;

  if (FT != 0) begin : g_ft
    logic [N_REGS-1:0] par_q, par_err;
    logic              err_q, ft2_q;
    for (genvar r = 0; r < N_REGS; r++) begin : g_chk
      assign par_err[r] = par_q[r] ^ (^regs_q[r]);
    end
    // Parity is refreshed alongside every register load so it tracks regs_q.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        par_q <= '0;
        err_q <= 1'b0;
        ft2_q <= 1'b0;
      end else begin
        for (int r = 0; r < N_REGS; r++) par_q[r] <= ^regs_d[r];
        err_q <= |par_err;
        ft2_q <= ft2_q | (|par_err);
      end
    end
    assign intr_FT1_o = (|par_err) & ~err_q;
    assign intr_FT2_o = ft2_q;
  end else begin : g_noft
    assign intr_FT1_o = 1'b0;
    assign intr_FT2_o = 1'b0;
  end

  logic unused_bus;
  assign unused_bus = ^{ahb.htrans_i[0], ahb.hsize_i, ahb.hburst_i, ahb.hprot_i, ahb.hmastlock_i};

  if (N_SOC_EV > N_COUNTERS + MCCU_N_CORES) begin : g_spare
    logic unused_ev;
    assign unused_ev = ^events_i[N_SOC_EV-1:N_COUNTERS+MCCU_N_CORES];
  end

endmodule

// File: tb/tb_pmu_ahb_slave.sv
// Directed bench for pmu_ahb_slave: transaction-level register model checked
// every cycle, plus hand-computed read-back and interrupt expectations.
module tb_pmu_ahb_slave;

  localparam int          N_REGS = 47;
  localparam int          NC     = 24;
  localparam int          NM     = 4;
  localparam int          MB     = 43;
  localparam logic [31:0] BASE   = 32'h80100000;
`ifdef PMU_AHB_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   events;
  logic          intr_overflow, intr_quota, intr_rdc, intr_ft1, intr_ft2;
  logic [NM-1:0] intr_mccu;
  int            n_cmp = 0;
  int            n_fail = 0;

  pmu_ahb_slave_if #(.DW(32)) ahb ();

  pmu_ahb_slave dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ahb             (ahb),
    .events_i        (events),
    .intr_overflow_o (intr_overflow),
    .intr_quota_o    (intr_quota),
    .intr_MCCU_o     (intr_mccu),
    .intr_RDC_o      (intr_rdc),
    .intr_FT1_o      (intr_ft1),
    .intr_FT2_o      (intr_ft2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: register file as plain words, plus the outstanding bus transfer.
  bit [31:0] m [N_REGS];
  bit        m_pend, m_pwr, m_pval, m_ovf, m_quo;
  int        m_pidx, m_err;

  task automatic model_step();
    bit [31:0]       o [N_REGS];
    longint unsigned sum;
    logic [31:0]     a;
    bit              hit;
    if (rst) begin
      foreach (m[r]) m[r] = '0;
      m_pend = 0; m_pwr = 0; m_pval = 0; m_pidx = 0; m_err = 0; m_ovf = 0; m_quo = 0;
      return;
    end
    o = m;
    m_ovf = |(o[26] & o[25]);
    sum = 0;
    for (int i = 0; i < NC; i++) if (o[27][i]) sum += o[1+i];
    m_quo = (o[27] != 0) && (sum >= longint'(o[28]));
    m[0][1] = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (o[0][1]) m[1+i] = 0;
      else if (o[0][0] && events[i]) begin
        if (o[1+i] == 32'hFFFF_FFFF) m[26][i] = 1'b1;
        m[1+i] = o[1+i] + 1;
      end
    end
    if (o[0][1]) m[26] = 0;
    for (int c = 0; c < NM; c++)
      if (o[0][2] && events[NC+c] && o[MB+c] != 0) m[MB+c] = o[MB+c] - 1;
    if (m_pend && m_pwr && m_pval)
      m[m_pidx] = (m_pidx == 26) ? (o[26] & ~ahb.hwdata_i) : ahb.hwdata_i;
    if (m_err == 1) begin
      m_err = 2; m_pend = 0;
    end else begin
      m_err = 0; m_pend = 0;
      if (ahb.hsel_i && ahb.hreadyi_i && ahb.htrans_i[1]) begin
        a   = ahb.haddr_i;
        hit = (((a & 32'hfff) >> 2) < N_REGS) && ((a & ~32'hfff) == (BASE & ~32'hfff));
        if (!hit && ERR_EN) m_err = 1;
        else begin
          m_pend = 1; m_pwr = ahb.hwrite_i; m_pval = hit;
          m_pidx = hit ? int'((a & 32'hfff) >> 2) : 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    logic [NM-1:0] em;
    @(negedge clk);
    for (int c = 0; c < NM; c++) em[c] = m[0][2] && (m[MB+c] == 0);
    chk("hreadyo", ahb.hreadyo_o, m_err != 1);
    chk("hresp", ahb.hresp_o, (m_err != 0) ? 2'b01 : 2'b00);
    chk("hrdata", ahb.hrdata_o, (m_pend && !m_pwr && m_pval) ? m[m_pidx] : 32'h0);
    chk("intr_overflow", intr_overflow, m_ovf);
    chk("intr_quota", intr_quota, m_quo);
    chk("intr_MCCU", intr_mccu, em);
    chk("intr_RDC", intr_rdc, 1'b0);
    chk("intr_FT1", intr_ft1, 1'b0);
    chk("intr_FT2", intr_ft2, 1'b0);
  end

  // Bus tasks start and end at 1 time unit after a rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ahb.hsel_i = 1; ahb.htrans_i = 2'b10; ahb.hwrite_i = 1; ahb.haddr_i = a;
    @(posedge clk); #1;
    ahb.hsel_i = 0; ahb.htrans_i = 2'b00; ahb.hwdata_i = d;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d,
                    output logic rdy, output logic [1:0] resp);
    ahb.hsel_i = 1; ahb.htrans_i = 2'b10; ahb.hwrite_i = 0; ahb.haddr_i = a;
    @(posedge clk); #1;
    ahb.hsel_i = 0; ahb.htrans_i = 2'b00;
    @(negedge clk);
    d = ahb.hrdata_o; rdy = ahb.hreadyo_o; resp = ahb.hresp_o;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic ev(input logic [31:0] e, input int n);
    events = e;
    repeat (n) begin @(posedge clk); #1; end
    events = '0;
  endtask

  initial begin
    logic [31:0] d;
    logic        rdy;
    logic [1:0]  resp;
    ahb.hsel_i = 0; ahb.hreadyi_i = 1; ahb.haddr_i = 0; ahb.hwrite_i = 0;
    ahb.htrans_i = 0; ahb.hsize_i = 3'b010; ahb.hburst_i = 0; ahb.hwdata_i = 0;
    ahb.hprot_i = 4'b0011; ahb.hmastlock_i = 0; events = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    rd(BASE + 32'h00, d, rdy, resp); chk("reset CTRL", d, 32'h0);

    // Soft clear, enable, 10 events on counter 0
    wr(BASE + 32'h00, 32'h2);
    wr(BASE + 32'h00, 32'h1);
    ev(32'h1, 10);
    rd(BASE + 32'h04, d, rdy, resp);
    chk("cnt0 after 10 ev", d, 32'd10);
    chk("cnt0 rd ready", rdy, 1'b1);
    chk("cnt0 rd resp", resp, 2'b00);

    // Wrap of counter 0 sets overflow
    wr(BASE + 32'h04, 32'hFFFF_FFFE);
    wr(BASE + 32'h64, 32'h1);
    ev(32'h1, 3);
    rd(BASE + 32'h04, d, rdy, resp); chk("cnt0 after wrap", d, 32'h1);
    rd(BASE + 32'h68, d, rdy, resp); chk("OVF_STATUS", d, 32'h1);
    chk("intr_overflow set", intr_overflow, 1'b1);
    wr(BASE + 32'h68, 32'h1);
    chk("intr_overflow cleared", intr_overflow, 1'b0);

    // Quota over counters 0 and 1
    wr(BASE + 32'h6C, 32'h3);
    wr(BASE + 32'h70, 32'd20);
    chk("quota below limit", intr_quota, 1'b0);
    ev(32'h3, 10);
    rd(BASE + 32'h08, d, rdy, resp); chk("cnt1 after 10 ev", d, 32'd10);
    chk("quota reached", intr_quota, 1'b1);

    // MCCU budget of core 0 runs out, others kept nonzero
    wr(BASE + 32'hB0, 32'd100);
    wr(BASE + 32'hB4, 32'd100);
    wr(BASE + 32'hB8, 32'd100);
    wr(BASE + 32'hAC, 32'd5);
    wr(BASE + 32'h00, 32'h5);
    ev(32'h0100_0000, 5);
    chk("intr_MCCU exhausted", intr_mccu, 4'b0001);
    ev(32'h0100_0000, 2);
    rd(BASE + 32'hAC, d, rdy, resp); chk("budget0 saturates", d, 32'h0);
    chk("intr_MCCU held", intr_mccu, 4'b0001);
    rd(BASE + 32'hB0, d, rdy, resp); chk("budget1 untouched", d, 32'd100);

    // Plain read/write, invalid accesses
    wr(BASE + 32'h74, 32'h1234_5678);
    wr(BASE + 32'hAC, 32'hCAFE_CAFE);
    rd(BASE + 32'hAC, d, rdy, resp); chk("budget0 rw", d, 32'hCAFE_CAFE);
    rd(32'h0801_0000, d, rdy, resp);
    chk("bad base data", d, 32'h0);
    chk("bad base ready", rdy, !ERR_EN);
    chk("bad base resp", resp, ERR_EN ? 2'b01 : 2'b00);
    rd(BASE + 32'hBC, d, rdy, resp);
    chk("index 47 data", d, 32'h0);
    chk("index 47 resp", resp, ERR_EN ? 2'b01 : 2'b00);
    wr(32'h0801_0074, 32'h0000_DEAD);
    rd(BASE + 32'h74, d, rdy, resp); chk("scratch after bad write", d, 32'h1234_5678);

    // Reset lands in a write data phase
    ahb.hsel_i = 1; ahb.htrans_i = 2'b10; ahb.hwrite_i = 1; ahb.haddr_i = BASE + 32'h78;
    @(posedge clk); #1;
    ahb.hsel_i = 0; ahb.htrans_i = 2'b00; ahb.hwdata_i = 32'h55;
    rst = 1;
    @(negedge clk);
    chk("rst hreadyo", ahb.hreadyo_o, 1'b1);
    chk("rst hresp", ahb.hresp_o, 2'b00);
    chk("rst intr_MCCU", intr_mccu, 4'b0000);
    chk("rst intr_quota", intr_quota, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    rd(BASE + 32'h78, d, rdy, resp); chk("scratch not written", d, 32'h0);
    rd(BASE + 32'h04, d, rdy, resp); chk("cnt0 after reset", d, 32'h0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pmu_ahb_slave.md
Name: pmu_ahb_slave

Overview:
- AHB-Lite slave exposing the performance monitoring unit register file.
- Holds 32-bit event counters, overflow/quota interrupt logic, a per-core MCCU budget block and optional register parity (FT).
- Sits on the SoC AHB bus at base haddr; event inputs come from the SoC event bus.

Parameters:
haddr, 32'h80100000, bus base address
hmask, 32'hfff, offset mask; bits set in hmask form the register offset
REG_WIDTH, 32, register and data width
N_REGS, 47, total registers; must be >= 29 + MCCU_N_CORES
N_COUNTERS, 24, event counters; must be <= N_SOC_EV
MCCU_N_CORES, 4, cores with MCCU budgets; N_COUNTERS + MCCU_N_CORES <= N_SOC_EV
N_SOC_EV, 32, event input width
FT, 0, 1 = parity-protected registers

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
hsel_i  in  1  slave select
hreadyi_i  in  1  bus ready in
haddr_i  in  32  address
hwrite_i  in  1  1 = write
htrans_i  in  2  transfer type; only NONSEQ/SEQ (bit1 = 1) are active
hsize_i  in  3  ignored; word access only
hburst_i  in  3  ignored
hwdata_i  in  REG_WIDTH  write data, sampled in data phase
hprot_i  in  4  ignored
hmastlock_i  in  1  ignored
hreadyo_o  out  1  slave ready
hresp_o  out  2  00 OKAY, 01 ERROR
hrdata_o  out  REG_WIDTH  read data
events_i  in  N_SOC_EV  per-cycle event pulses
intr_overflow_o  out  1  counter overflow interrupt
intr_quota_o  out  1  quota interrupt
intr_MCCU_o  out  MCCU_N_CORES  per-core budget exhausted
intr_RDC_o  out  1  reserved, tied 0
intr_FT1_o  out  1  parity error pulse
intr_FT2_o  out  1  sticky parity error

Behaviour:
- Reset: all registers 0; hreadyo_o = 1; hresp_o = 00; hrdata_o = 0; all interrupts 0.
- Address phase: the access is active when hsel_i & hreadyi_i & htrans_i[1].
- Decode: index = (haddr_i & hmask) >> 2. The access is valid if (haddr_i & ~hmask) == (haddr & ~hmask) and index < N_REGS.
- The address phase is registered; the data phase occurs the next cycle.
- Write: hwdata_i is written to the register in the data phase.
- Read: hrdata_o is driven in the data phase with hreadyo_o = 1 and hresp_o = 00 (zero wait states).
- Register map (word index):
  - 0 CTRL: bit0 count enable; bit1 soft clear, self-clearing, zeroes counters and OVF_STATUS the next cycle; bit2 MCCU enable.
  - 1..N_COUNTERS: counters. Counter i-1 increments by 1 per cycle while events_i[i-1] = 1 and CTRL.bit0 = 1.
  - 25 OVF_MASK.
  - 26 OVF_STATUS: sticky, write-1-to-clear.
  - 27 QUOTA_MASK.
  - 28 QUOTA_LIMIT.
  - 29..N_REGS-MCCU_N_CORES-1: scratch read/write.
  - Last MCCU_N_CORES registers (0xAC..0xB8 at defaults): MCCU budgets.
- Counter wrap from 0xFFFFFFFF to 0 sets OVF_STATUS[i]. intr_overflow_o = |(OVF_STATUS & OVF_MASK), registered.
- Quota: intr_quota_o (registered) = 1 when the sum of counters selected by QUOTA_MASK is >= QUOTA_LIMIT and QUOTA_MASK != 0. Sum width is 32 + clog2(N_COUNTERS) bits, no wrap.
- MCCU: while CTRL.bit2 = 1, budget c decrements by 1 when events_i[N_COUNTERS+c] = 1, saturating at 0. intr_MCCU_o[c] = CTRL.bit2 & (budget c == 0).
- Bus write and hardware update to the same register in the same cycle: bus write wins.
- FT=1:
  - Each register stores an even-parity bit, recomputed on every update.
  - A continuous parity check raises intr_FT1_o as a 1-cycle pulse per detection, and sets intr_FT2_o sticky until reset.
  - FT=0: both are tied 0.
- Reset mid-transfer: the pending data phase is aborted; no write occurs.

Optional Feature:
PMU_AHB_ERR_RESP_EN
- Defined: an invalid access gives a two-cycle AHB ERROR. Cycle 1: hreadyo_o = 0, hresp_o = 01. Cycle 2: hreadyo_o = 1, hresp_o = 01. Writes are discarded.
- Undefined: an invalid access gives OKAY with zero wait states; writes are ignored and reads return 0.

Decomposition:
- Package pmu_ahb_pkg: register index constants (CTRL, OVF_MASK, OVF_STATUS, QUOTA_MASK, QUOTA_LIMIT, MCCU base), HRESP/HTRANS encodings, CTRL bit positions.
- Sub-module pmu_ahb_if: AHB address/data-phase tracking, decode and error FSM. FSM states are IDLE, DATA, ERR1, ERR2.
- Counters, quota, MCCU and FT logic stay in the top level.

Test Plan:
- Write 0x00 = 0x2, then 0x00 = 0x1; set events_i = 0x1 for 10 cycles -> counter 0 (0x04) reads 10; OKAY, zero wait.
- Write 0x04 = 0xFFFFFFFE and 0x64 = 0x1, enable counting, events_i[0] = 1 for 3 cycles -> counter 0 = 1, OVF_STATUS bit0 = 1, intr_overflow_o = 1; write 0x68 = 0x1 -> interrupt clears.
- Write 0x6C = 0x3 and 0x70 = 20, events_i = 0x3 for 10 cycles -> intr_quota_o = 1.
- Write 0xAC = 5 and 0x00 = 0x5, events_i[24] = 1 for 5 cycles -> intr_MCCU_o = 4'b0001, budget reads 0 and stays 0.
- Write 0xAC = 0xcafecafe then read 0xAC -> 0xcafecafe. Access 0x08010000 (outside base) with PMU_AHB_ERR_RESP_EN -> two-cycle ERROR (hresp_o = 01); without it -> OKAY, read 0.
- Assert rst_i during a write data phase -> register unchanged, all outputs at reset values.
